pulse_emitter: RTL and testbench

Generates clean, glitch-free pulses on a single output line from single-cycle request strobes. Each pulse is held high for exactly HIGH_LEN cycles and is followed by at least GAP_LEN low cycles. Requests that arrive while a pulse is in flight are queued in a saturating pending counter. It is the transmit-side counterpart of the team's pulse filter/tracer: every emitted pulse is long and stable enough for a downstream filter with FILTER_LEN < HIGH_LEN to report exactly one pulse.

---
 rtl/pulse_emitter.sv | 157 +++++++++++++++
 tb/tb_pulse_emitter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_emitter.sv
// pulse_emitter: turns single-cycle request strobes into clean pulses on line_out.
// Each pulse is exactly HIGH_LEN cycles high and is followed by at least GAP_LEN low cycles.
// Requests that arrive during a pulse queue in a saturating counter; a full queue drops them and sets overflow.
// Ports: clk, rst (async active-high), trig_in (request strobe), clr_ovf (clear overflow),
//        line_out (pulse line), busy (not idle), done (first gap cycle strobe),
//        pending (queued requests), overflow (sticky drop flag). All outputs are registered.
module pulse_emitter #(
  parameter int HIGH_LEN    = 4,
  parameter int GAP_LEN     = 4,
  parameter int MAX_PENDING = 7,
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig_in,
  input  logic          clr_ovf,
  output logic          line_out,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int MAX_LEN = (HIGH_LEN > GAP_LEN) ? HIGH_LEN : GAP_LEN;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_LEN - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          line_q, busy_q, done_q;

  logic cnt_zero, pend_nz;
  logic start, deq, direct, enq, drop;

  assign cnt_zero = (cnt_q == '0);
  assign pend_nz  = (pending_q != '0);

  // A pulse may only begin from IDLE or on the last GAP edge. Queued work
  // takes precedence over a fresh strobe, which then gets queued instead.
  always_comb begin
    start = 1'b0;
    deq   = 1'b0;
    case (state_q)
      S_IDLE: begin
        start = trig_in | pend_nz;
        deq   = pend_nz;
      end
      S_GAP: begin
        start = cnt_zero & (trig_in | pend_nz);
        deq   = cnt_zero & pend_nz;
      end
      default: begin
        start = 1'b0;
        deq   = 1'b0;
      end
    endcase
  end

  // A strobe that launches a pulse with an empty queue is consumed on the spot.
  assign direct = start & ~deq;
  assign enq    = trig_in & ~direct;
  // A dequeue on the same edge frees a slot, so only enqueue-without-dequeue can drop.
  assign drop   = enq & ~deq & (pending_q == PEND_MAX);

  always_comb begin
    pending_d = pending_q;
    if (enq && !drop && !deq) begin
      pending_d = pending_q + PW'(1);
    end else if (deq && !enq) begin
      pending_d = pending_q - PW'(1);
    end
  end

  // Setting wins over clearing when both happen on one edge.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      line_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_HIGH;
            cnt_q   <= HIGH_LOAD;
            line_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt_zero) begin
            state_q <= S_GAP;
            cnt_q   <= GAP_LOAD;
            line_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          if (cnt_zero) begin
            if (start) begin
              state_q <= S_HIGH;
              cnt_q   <= HIGH_LOAD;
              line_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          line_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign line_out = line_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_emitter.sv
// tb_pulse_emitter: self-checking bench for pulse_emitter (HIGH_LEN=4, GAP_LEN=4, MAX_PENDING=2).
// A time-based reference model (pulse start edge + arithmetic) is compared every cycle,
// plus directed scenarios with literal expectations and a randomized run.
module tb_pulse_emitter;

  localparam int H    = 4;
  localparam int G    = 4;
  localparam int MAXP = 2;
  localparam int PW   = $clog2(MAXP + 1);
  localparam int FILT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          trig_in;
  logic          clr_ovf;
  logic          line_out;
  logic          busy;
  logic          done;
  logic [PW-1:0] pending;
  logic          overflow;

  pulse_emitter #(
    .HIGH_LEN   (H),
    .GAP_LEN    (G),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig_in (trig_in),
    .clr_ovf (clr_ovf),
    .line_out(line_out),
    .busy    (busy),
    .done    (done),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrs   = 0;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pulse is described by the edge s on which it started.
  // It is high in cycles s+1..s+H, low in s+H+1..s+H+G, and the next pulse may
  // start on edge s+H+G at the earliest.
  int m_edge = 0;
  int m_s    = 0;
  int m_pend = 0;
  bit m_act  = 1'b0;
  bit m_ovf  = 1'b0;
  bit e_line = 1'b0;
  bit e_busy = 1'b0;
  bit e_done = 1'b0;

  task automatic model_step();
    bit can_start, deq, consumed;
    int p0;
    m_edge++;
    if (rst) begin
      m_act = 1'b0; m_pend = 0; m_ovf = 1'b0;
      e_line = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      return;
    end
    deq = 1'b0;
    consumed = 1'b0;
    can_start = !m_act || (m_edge - m_s == H + G);
    if (can_start) begin
      if (m_pend > 0 || trig_in) begin
        m_act = 1'b1;
        m_s   = m_edge;
        if (m_pend > 0) deq = 1'b1;
        else            consumed = 1'b1;
      end else begin
        m_act = 1'b0;
      end
    end
    p0 = m_pend;
    if (deq) m_pend--;
    if (trig_in && !consumed) begin
      if (!deq && p0 == MAXP) m_ovf = 1'b1;
      else                    m_pend++;
    end else if (clr_ovf) begin
      m_ovf = 1'b0;
    end
    if (trig_in && !consumed && !deq && p0 == MAXP) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    e_busy = m_act;
    e_line = m_act && (m_edge - m_s) < H;
    e_done = m_act && (m_edge - m_s) == H;
  endtask

  // Observation counters fed from DUT outputs; the filter stand-in reports one
  // event each time line_out has been high for FILT consecutive cycles.
  int rise_cnt = 0;
  int done_cnt = 0;
  int filt_cnt = 0;
  int hi_run   = 0;
  bit prev_line = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (!rst) begin
        check("model_line_out", int'(line_out), int'(e_line));
        check("model_busy", int'(busy), int'(e_busy));
        check("model_done", int'(done), int'(e_done));
        check("model_pending", int'(pending), m_pend);
        check("model_overflow", int'(overflow), int'(m_ovf));
      end
      if (line_out && !prev_line) rise_cnt++;
      if (done) done_cnt++;
      if (line_out) hi_run++;
      else          hi_run = 0;
      if (hi_run == FILT) filt_cnt++;
      prev_line = line_out;
    end
  end

  task automatic step(input bit t, input bit c);
    trig_in = t;
    clr_ovf = c;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("reach_idle", int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] line_pat, done_pat, busy_pat;
    int r0, d0, f0;
    rst = 1'b1; trig_in = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_line_out", int'(line_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_pending", int'(pending), 0);
    check("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Single request: 4 high, done on first low cycle, busy for 8 cycles.
    line_pat = 12'b1111_0000_0000;
    done_pat = 12'b0000_1000_0000;
    busy_pat = 12'b1111_1111_0000;
    step(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("single_line", int'(line_out), int'(line_pat[11-i]));
      check("single_done", int'(done), int'(done_pat[11-i]));
      check("single_busy", int'(busy), int'(busy_pat[11-i]));
      check("single_pending", int'(pending), 0);
      step(1'b0, 1'b0);
    end

    // Burst of three consecutive requests.
    wait_idle();
    r0 = rise_cnt; d0 = done_cnt;
    step(1'b1, 1'b0); check("burst_pend0", int'(pending), 0);
    step(1'b1, 1'b0); check("burst_pend1", int'(pending), 1);
    step(1'b1, 1'b0); check("burst_pend2", int'(pending), 2);
    step(1'b0, 1'b0);
    wait_idle();
    check("burst_pulses", rise_cnt - r0, 3);
    check("burst_dones", done_cnt - d0, 3);

    // Overflow: five requests, only three pulses, sticky flag and clear rules.
    r0 = rise_cnt;
    repeat (5) step(1'b1, 1'b0);
    check("ovf_set", int'(overflow), 1);
    step(1'b0, 1'b0);
    wait_idle();
    check("ovf_pulses", rise_cnt - r0, 3);
    check("ovf_sticky", int'(overflow), 1);
    step(1'b0, 1'b1);
    check("ovf_cleared", int'(overflow), 0);
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("ovf_set_beats_clr", int'(overflow), 1);
    step(1'b0, 1'b1);
    check("ovf_clr_again", int'(overflow), 0);
    wait_idle();

    // Enqueue and dequeue on the final gap edge: pending holds, no gap extension.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    check("simul_last_gap_line", int'(line_out), 0);
    check("simul_last_gap_pend", int'(pending), 1);
    step(1'b1, 1'b0);
    check("simul_next_line", int'(line_out), 1);
    check("simul_next_pend", int'(pending), 1);
    step(1'b0, 1'b0);
    wait_idle();

    // Loopback: five spaced requests seen as five filtered pulses.
    r0 = rise_cnt; f0 = filt_cnt;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0);
    end
    wait_idle();
    check("loop_filter_events", filt_cnt - f0, 5);
    check("loop_pulses", rise_cnt - r0, 5);

    // Reset during the 2nd high cycle of a pulse with two requests queued.
    repeat (4) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("pre_rst_line", int'(line_out), 1);
    check("pre_rst_pend", int'(pending), 2);
    check("pre_rst_ovf", int'(overflow), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_line", int'(line_out), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_pend", int'(pending), 0);
    check("async_rst_ovf", int'(overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    r0 = rise_cnt;
    repeat (20) step(1'b0, 1'b0);
    check("post_rst_no_pulse", rise_cnt - r0, 0);

    // Randomized traffic, occasional resets; the model checks every cycle.
    repeat (1500) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      end
    end
    repeat (20) step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
